// File: rtl/if_fetch_unit_if.sv
// Bundle of branch-control, instruction-memory and decode-handoff signals
// around the fetch stage; master is the fetch unit, slave is its environment.
interface if_fetch_unit_if #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned INSTR_W = 32
);
   logic               br_valid;
   logic [1:0]         bs;
   logic               ps;
   logic               z;
   logic [ADDR_W-1:0]  bra;
   logic [ADDR_W-1:0]  raa;

   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_rdata;

   logic               id_valid;
   logic               id_ready;
   logic [INSTR_W-1:0] id_instr;
   logic [ADDR_W-1:0]  id_pc;
   logic [ADDR_W-1:0]  id_pc1;

   modport master (
      input  br_valid, bs, ps, z, bra, raa,
      input  imem_ack, imem_rdata,
      input  id_ready,
      output imem_req, imem_addr,
      output id_valid, id_instr, id_pc, id_pc1
   );

   modport slave (
      output br_valid, bs, ps, z, bra, raa,
      output imem_ack, imem_rdata,
      output id_ready,
      input  imem_req, imem_addr,
      input  id_valid, id_instr, id_pc, id_pc1
   );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues req/ack fetches and buffers up
// to two instructions for decode; taken branches flush all in-flight work.
//
// state   | meaning
// S_IDLE  | no fetch request outstanding
// S_FETCH | request outstanding, its data will be pushed on ack
// S_DROP  | request outstanding, its data is discarded on ack (redirect seen)
module if_fetch_unit #(
   parameter int unsigned       ADDR_W   = 16,
   parameter int unsigned       INSTR_W  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic             clk,
   input logic             rst_n,
   if_fetch_unit_if.master bus
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DROP} state_t;

   state_t             state;
   logic               imem_req_q;
   logic [ADDR_W-1:0]  pc;
   logic [ADDR_W-1:0]  fetch_addr;
   logic [INSTR_W-1:0] fifo_instr [2];
   logic [ADDR_W-1:0]  fifo_pc    [2];
   logic               rd_ptr;
   logic               wr_ptr;
   logic [1:0]         count;

   logic               cond_taken;
   logic               redirect;
   logic [ADDR_W-1:0]  target;
   logic               xfer;
   logic               push;
   logic               pop;
   logic [1:0]         count_next;
   logic [ADDR_W-1:0]  pc_next;
   logic               busy_next;
   logic               issue;

   // Issue is decided on post-edge occupancy so a zero-wait memory streams
   // one instruction per cycle.
   always_comb begin
      cond_taken = bus.z ^ bus.ps;
      redirect   = bus.br_valid &&
                   (bus.bs[1] || ((bus.bs == 2'b01) && cond_taken));
      target     = (bus.bs == 2'b10) ? bus.raa : bus.bra;
      xfer       = imem_req_q && bus.imem_ack;
      push       = xfer && (state == S_FETCH) && !redirect;
      pop        = (count != 2'd0) && bus.id_ready && !redirect;

      if (redirect) begin
         count_next = 2'd0;
      end else begin
         count_next = count + {1'b0, push} - {1'b0, pop};
      end

      if (redirect) begin
         pc_next = target;
      end else if (push) begin
         pc_next = fetch_addr + ADDR_W'(1);
      end else begin
         pc_next = pc;
      end

      busy_next = (state != S_IDLE) && !xfer;
      issue     = !busy_next && (count_next != 2'd2);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         imem_req_q    <= 1'b0;
         pc            <= RESET_PC;
         fetch_addr    <= RESET_PC;
         fifo_instr[0] <= '0;
         fifo_instr[1] <= '0;
         fifo_pc[0]    <= RESET_PC;
         fifo_pc[1]    <= RESET_PC;
         rd_ptr        <= 1'b0;
         wr_ptr        <= 1'b0;
         count         <= 2'd0;
      end else begin
         pc    <= pc_next;
         count <= count_next;

         if (push) begin
            fifo_instr[wr_ptr] <= bus.imem_rdata;
            fifo_pc[wr_ptr]    <= fetch_addr;
         end

         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end

         if (redirect) begin
            wr_ptr <= rd_ptr;
         end else if (push) begin
            wr_ptr <= ~wr_ptr;
         end

         // A request stays on the bus until acked, even across redirects.
         case (state)
            S_IDLE, S_FETCH, S_DROP: begin
               if (issue) begin
                  state      <= S_FETCH;
                  imem_req_q <= 1'b1;
                  fetch_addr <= pc_next;
               end else if (busy_next) begin
                  state      <= (redirect || (state == S_DROP)) ? S_DROP : S_FETCH;
                  imem_req_q <= 1'b1;
               end else begin
                  state      <= S_IDLE;
                  imem_req_q <= 1'b0;
               end
            end
            default: begin
               state      <= S_IDLE;
               imem_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.imem_req  = imem_req_q;
   assign bus.imem_addr = fetch_addr;
   assign bus.id_valid  = (count != 2'd0);
   assign bus.id_instr  = fifo_instr[rd_ptr];
   assign bus.id_pc     = fifo_pc[rd_ptr];
   assign bus.id_pc1    = fifo_pc[rd_ptr] + ADDR_W'(1);

endmodule
